// File: rtl/echo_delay_ctrl_if.sv
// rtl/echo_delay_ctrl_if.sv - delay RAM port bundle between echo_delay_ctrl and the single-port RAM
interface echo_delay_ctrl_if #(
  parameter int ADDR_SZ = 10,
  parameter int DATA_SZ = 10
);
  logic [ADDR_SZ-1:0] ram_addr;
  logic               ram_we;
  logic [DATA_SZ-1:0] ram_wdata;
  logic [DATA_SZ-1:0] ram_rdata;

  modport master (output ram_addr, output ram_we, output ram_wdata, input ram_rdata);
  modport slave  (input ram_addr, input ram_we, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - per-sample read-then-write sequencer for the echo delay RAM
module echo_delay_ctrl #(
  parameter int ADDR_SZ = 10,
  parameter int DATA_SZ = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_tick,
  input  logic [ADDR_SZ-1:0]  delay,
  input  logic [DATA_SZ-1:0]  data_in,
  echo_delay_ctrl_if.master   ram,
  output logic [DATA_SZ-1:0]  data_out,
  output logic                data_valid,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

  state_t             state, state_next;
  logic [ADDR_SZ-1:0] wptr, wptr_next;
  logic [DATA_SZ-1:0] sample, sample_next;
  logic [ADDR_SZ-1:0] addr_q, addr_next;
  logic               we_q, we_next;
  logic [DATA_SZ-1:0] wdata_q, wdata_next;
  logic [DATA_SZ-1:0] out_next;
  logic               valid_next, busy_next, overrun_next;
  logic               tick_ok;

  assign tick_ok       = sample_tick && enable;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_we    = we_q;
  assign ram.ram_wdata = wdata_q;

  // Outputs are registered, so each value is computed for the state being entered.
  // The read address is formed from the delay at the accept edge, which is the
  // only point the delay is ever used, so no separate delay copy is kept.
  always_comb begin
    state_next   = state;
    wptr_next    = wptr;
    sample_next  = sample;
    addr_next    = addr_q;
    we_next      = 1'b0;
    wdata_next   = wdata_q;
    out_next     = data_out;
    valid_next   = 1'b0;
    busy_next    = busy;
    overrun_next = overrun;
    case (state)
      IDLE: begin
        if (tick_ok) begin
          state_next  = READ;
          sample_next = data_in;
          addr_next   = wptr - delay;
          busy_next   = 1'b1;
        end
      end
      READ: state_next = CAPTURE;
      CAPTURE: begin
        state_next = WRITE;
        out_next   = ram.ram_rdata;
        valid_next = 1'b1;
        addr_next  = wptr;
        we_next    = 1'b1;
        wdata_next = sample;
      end
      WRITE: begin
        state_next = IDLE;
        wptr_next  = wptr + 1'b1;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
    if (tick_ok && state != IDLE) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wptr       <= '0;
      sample     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      wptr       <= wptr_next;
      sample     <= sample_next;
      addr_q     <= addr_next;
      we_q       <= we_next;
      wdata_q    <= wdata_next;
      data_out   <= out_next;
      data_valid <= valid_next;
      busy       <= busy_next;
      overrun    <= overrun_next;
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb/tb_echo_delay_ctrl.sv - directed vector bench for echo_delay_ctrl with an 8-deep RAM model
module tb_echo_delay_ctrl;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       sample_tick;
  logic [2:0] delay;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       overrun;
  logic       mem_clear;
  logic [7:0] mem [0:7];

  int n_checks = 0;
  int n_fail   = 0;

  echo_delay_ctrl_if #(.ADDR_SZ(3), .DATA_SZ(8)) ram ();

  echo_delay_ctrl #(.ADDR_SZ(3), .DATA_SZ(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sample_tick (sample_tick),
    .delay       (delay),
    .data_in     (data_in),
    .ram         (ram),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM: read data returns the old contents one cycle later.
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (ram.ram_we) begin
      mem[ram.ram_addr] <= ram.ram_wdata;
    end
    ram.ram_rdata <= mem[ram.ram_addr];
  end

  typedef struct {
    logic [7:0] din;
    logic [2:0] dly;
    logic [2:0] raddr;
    logic [2:0] waddr;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [29];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    sample_tick = 1'b0;
    step();
    reset = 1'b0;
    check({tag, " addr"},  32'(ram.ram_addr),  0);
    check({tag, " we"},    32'(ram.ram_we),    0);
    check({tag, " wdata"}, 32'(ram.ram_wdata), 0);
    check({tag, " dout"},  32'(data_out),      0);
    check({tag, " dv"},    32'(data_valid),    0);
    check({tag, " busy"},  32'(busy),          0);
    check({tag, " ovr"},   32'(overrun),       0);
  endtask

  // Tick in cycle T; checks T+1 (READ), T+2 (CAPTURE), T+3 (WRITE), T+4 (IDLE).
  task automatic do_tick(input string tag, input logic [7:0] d, input logic [2:0] dl,
                         input logic [2:0] ra, input logic [2:0] wa, input logic [7:0] eo,
                         input logic drop_en);
    enable = 1'b1;
    data_in = d;
    delay = dl;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    data_in = ~d;
    delay = dl + 3'd2;
    if (drop_en) enable = 1'b0;
    check({tag, " busy1"}, 32'(busy), 1);
    check({tag, " we1"},   32'(ram.ram_we), 0);
    check({tag, " raddr"}, 32'(ram.ram_addr), 32'(ra));
    check({tag, " dv1"},   32'(data_valid), 0);
    step();
    check({tag, " dv2"},   32'(data_valid), 0);
    check({tag, " we2"},   32'(ram.ram_we), 0);
    step();
    check({tag, " we3"},   32'(ram.ram_we), 1);
    check({tag, " waddr"}, 32'(ram.ram_addr), 32'(wa));
    check({tag, " wdata"}, 32'(ram.ram_wdata), 32'(d));
    check({tag, " dv3"},   32'(data_valid), 1);
    check({tag, " dout"},  32'(data_out), 32'(eo));
    step();
    check({tag, " busy4"}, 32'(busy), 0);
    check({tag, " we4"},   32'(ram.ram_we), 0);
    check({tag, " dv4"},   32'(data_valid), 0);
    check({tag, " hold"},  32'(data_out), 32'(eo));
    enable = 1'b1;
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    mem_clear = 1'b1;
    enable = 1'b1;
    sample_tick = 1'b0;
    delay = '0;
    data_in = '0;

    // Phase A: delay 3 from a zeroed RAM, wptr 0..5.
    vecs[0] = '{8'd1, 3'd3, 3'd5, 3'd0, 8'd0};
    vecs[1] = '{8'd2, 3'd3, 3'd6, 3'd1, 8'd0};
    vecs[2] = '{8'd3, 3'd3, 3'd7, 3'd2, 8'd0};
    vecs[3] = '{8'd4, 3'd3, 3'd0, 3'd3, 8'd1};
    vecs[4] = '{8'd5, 3'd3, 3'd1, 3'd4, 8'd2};
    vecs[5] = '{8'd6, 3'd3, 3'd2, 3'd5, 8'd3};
    // Phase B: delay 0 (full depth) for 20 ticks starting at wptr 6; RAM holds 1..6 at 0..5.
    for (int k = 0; k < 20; k++) begin
      vecs[6+k].din   = 8'(k + 10);
      vecs[6+k].dly   = 3'd0;
      vecs[6+k].raddr = 3'(6 + k);
      vecs[6+k].waddr = 3'(6 + k);
      if (k >= 8)     vecs[6+k].dout = 8'(k + 2);
      else if (k < 2) vecs[6+k].dout = 8'd0;
      else            vecs[6+k].dout = 8'(k - 1);
    end
    // Phase C: after a reset wptr is 0 again; delay 1 reads address 7 (27 from phase B).
    vecs[26] = '{8'd40, 3'd1, 3'd7, 3'd0, 8'd27};
    vecs[27] = '{8'd41, 3'd1, 3'd0, 3'd1, 8'd40};
    vecs[28] = '{8'd42, 3'd1, 3'd1, 3'd2, 8'd41};

    step();
    step();
    do_reset("init");
    mem_clear = 1'b0;

    for (int i = 0; i < 29; i++) begin
      if (i == 26) do_reset("pre_c");
      do_tick($sformatf("v%0d", i), vecs[i].din, vecs[i].dly, vecs[i].raddr,
              vecs[i].waddr, vecs[i].dout, 1'b0);
    end

    // Overrun: wptr 3, ticks at T, T+2, T+3 dropped-after-first, T+4 accepted.
    data_in = 8'd50; delay = 3'd1; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("ovr t1", 32'(overrun), 0);
    check("ovr raddr", 32'(ram.ram_addr), 2);
    step();
    check("ovr t2", 32'(overrun), 0);
    data_in = 8'd60; sample_tick = 1'b1;
    step();
    check("ovr t3", 32'(overrun), 1);
    check("ovr wdata", 32'(ram.ram_wdata), 50);
    check("ovr waddr", 32'(ram.ram_addr), 3);
    check("ovr dout", 32'(data_out), 42);
    data_in = 8'd61;
    step();
    check("ovr t4 busy", 32'(busy), 0);
    check("ovr t4", 32'(overrun), 1);
    do_tick("ovr_t4", 8'd51, 3'd1, 3'd3, 3'd4, 8'd50, 1'b0);
    step();
    check("ovr sticky", 32'(overrun), 1);
    do_reset("ovr_clr");

    // Enable gating: ticks ignored silently, then enable dropped mid-transaction.
    enable = 1'b0;
    sample_tick = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("en%0d busy", c), 32'(busy), 0);
      check($sformatf("en%0d we", c), 32'(ram.ram_we), 0);
      check($sformatf("en%0d ovr", c), 32'(overrun), 0);
    end
    do_tick("en_drop", 8'd70, 3'd2, 3'd6, 3'd0, 8'd26, 1'b1);

    // Reset in the CAPTURE cycle: wptr 1, nothing written, wptr stays 0 afterwards.
    data_in = 8'd80; delay = 3'd1; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("mid raddr", 32'(ram.ram_addr), 0);
    step();
    do_reset("mid");
    step();
    check("mid no we", 32'(ram.ram_we), 0);
    check("mid no dv", 32'(data_valid), 0);
    check("mid mem1", 32'(mem[1]), 41);
    do_tick("post_mid", 8'd90, 3'd1, 3'd7, 3'd0, 8'd27, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
